// File: rtl/mem_map_ctrl_if.sv
// Request/memory/response bundle for mem_map_ctrl.
// The slave modport is the controller's view; the master modport is the CPU/memory side.
interface mem_map_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_wdata;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_wdata, mem_rdata, rsp_ready,
    output req_ready, mem_en, mem_we, mem_sel, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_we, req_size, req_wdata, mem_rdata, rsp_ready,
    input  req_ready, mem_en, mem_we, mem_sel, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_map_ctrl.sv
// Address decoder and single-outstanding access sequencer for TEXT/DATA/STACK/MMIO windows.
// Define MEM_MAP_MMIO_WAIT_EN to insert MMIO_WAIT wait cycles on MMIO accesses.
module mem_map_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int INST_MEM_DEPTH = 1024,
  parameter int DATA_MEM_DEPTH = 4096,
  parameter int MMIO_MEM_SIZE  = 64,
  parameter int MMIO_WAIT      = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_map_ctrl_if.slave bus
);

  localparam int DIV = DATA_MEM_DEPTH / 2;

  localparam logic [ADDR_W-1:0] TEXT_BASE  = ADDR_W'(32'h0040_0000);
  localparam logic [ADDR_W-1:0] DATA_BASE  = ADDR_W'(32'h1001_0000);
  localparam logic [ADDR_W-1:0] STACK_TOP  = ADDR_W'(32'h7fff_f000);
  localparam logic [ADDR_W-1:0] STACK_LO   = ADDR_W'(32'h7fff_f000 - DIV);
  localparam logic [ADDR_W-1:0] MMIO_BASE  = ADDR_W'(32'hffff_0000);
  localparam logic [ADDR_W-1:0] TEXT_SIZE  = ADDR_W'(INST_MEM_DEPTH);
  localparam logic [ADDR_W-1:0] HALF_SIZE  = ADDR_W'(DIV);
  localparam logic [ADDR_W-1:0] MMIO_SIZE  = ADDR_W'(MMIO_MEM_SIZE);

  localparam logic [1:0] SEL_TEXT  = 2'd0;
  localparam logic [1:0] SEL_DATA  = 2'd1;
  localparam logic [1:0] SEL_STACK = 2'd2;
  localparam logic [1:0] SEL_MMIO  = 2'd3;

  if (MMIO_WAIT < 1 || MMIO_WAIT > 15) begin : g_wait_range
    $error("mem_map_ctrl: MMIO_WAIT must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
`ifdef MEM_MAP_MMIO_WAIT_EN
    WAIT,
`endif
    DATA,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] text_off, data_off, stack_off, mmio_off;
  logic [ADDR_W-1:0] dec_addr;
  logic [1:0]        dec_sel;
  logic [3:0]        dec_be;
  logic              dec_hit, dec_misalign, dec_err;

  assign text_off  = bus.req_addr - TEXT_BASE;
  assign data_off  = bus.req_addr - DATA_BASE;
  assign stack_off = bus.req_addr - STACK_LO;
  assign mmio_off  = bus.req_addr - MMIO_BASE;

  // Unsigned offset compare covers both window edges; stack is indexed from its top downwards.
  always_comb begin
    dec_hit  = 1'b1;
    dec_sel  = SEL_TEXT;
    dec_addr = '0;
    if (text_off < TEXT_SIZE) begin
      dec_sel  = SEL_TEXT;
      dec_addr = text_off;
    end else if (data_off < HALF_SIZE) begin
      dec_sel  = SEL_DATA;
      dec_addr = data_off;
    end else if (stack_off < HALF_SIZE) begin
      dec_sel  = SEL_STACK;
      dec_addr = HALF_SIZE + (bus.req_addr - STACK_TOP);
    end else if (mmio_off < MMIO_SIZE) begin
      dec_sel  = SEL_MMIO;
      dec_addr = mmio_off;
    end else begin
      dec_hit  = 1'b0;
    end

    case (bus.req_size)
      2'd0:    dec_be = 4'b0001 << bus.req_addr[1:0];
      2'd1:    dec_be = 4'b0011 << bus.req_addr[1:0];
      default: dec_be = 4'b1111;
    endcase

    dec_misalign = ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00)) ||
                   ((bus.req_size == 2'd1) && bus.req_addr[0]);
    dec_err = !dec_hit || dec_misalign || (bus.req_size == 2'd3) ||
              (bus.req_we && (dec_sel == SEL_TEXT));
  end

`ifdef MEM_MAP_MMIO_WAIT_EN
  localparam logic [3:0] WAIT_LAST = 4'(MMIO_WAIT - 1);
  logic [3:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == WAIT)
      wait_cnt <= wait_cnt + 4'd1;
    else
      wait_cnt <= '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.mem_en    = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_nxt = dec_err ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_en = 1'b1;
`ifdef MEM_MAP_MMIO_WAIT_EN
        state_nxt  = (bus.mem_sel == SEL_MMIO) ? WAIT : DATA;
`else
        state_nxt  = DATA;
`endif
      end
`ifdef MEM_MAP_MMIO_WAIT_EN
      WAIT: begin
        if (wait_cnt == WAIT_LAST)
          state_nxt = DATA;
      end
`endif
      DATA: state_nxt = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Faulting requests never touch the memory-side registers; they only arm an error response.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_sel   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.req_valid) begin
        if (dec_err) begin
          bus.rsp_err   <= 1'b1;
          bus.rsp_rdata <= '0;
        end else begin
          bus.rsp_err   <= 1'b0;
          bus.mem_we    <= bus.req_we;
          bus.mem_sel   <= dec_sel;
          bus.mem_addr  <= dec_addr;
          bus.mem_be    <= dec_be;
          bus.mem_wdata <= bus.req_wdata;
        end
      end
      if (state == DATA)
        bus.rsp_rdata <= bus.mem_we ? '0 : bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Randomized and directed bench for mem_map_ctrl against a window-table reference model.
// Build with or without MEM_MAP_MMIO_WAIT_EN; the model follows the same macro.
module tb_mem_map_ctrl;

  localparam int INST    = 1024;
  localparam int DATA_D  = 4096;
  localparam int DIV     = DATA_D / 2;
  localparam int MMIO_SZ = 64;
  localparam int WAIT_P  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errCount = 0;
  int   checkCount = 0;

  mem_map_ctrl_if #(.ADDR_W(32)) bus ();

  mem_map_ctrl #(
    .ADDR_W(32), .INST_MEM_DEPTH(INST), .DATA_MEM_DEPTH(DATA_D),
    .MMIO_MEM_SIZE(MMIO_SZ), .MMIO_WAIT(WAIT_P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: windows as inclusive address ranges, physical index from plain subtraction.
  function automatic void refModel(input logic [31:0] a, input bit we, input logic [1:0] sz,
                                   output bit err, output logic [1:0] sel,
                                   output logic [31:0] pa, output logic [3:0] be,
                                   output int lat);
    longint ua;
    bit hit;
    ua  = a;
    hit = 1'b1;
    sel = 2'd0;
    pa  = 32'd0;
    if (ua >= 64'h0040_0000 && ua <= 64'h0040_0000 + INST - 1) begin
      sel = 2'd0; pa = 32'(ua - 64'h0040_0000);
    end else if (ua >= 64'h1001_0000 && ua <= 64'h1001_0000 + DIV - 1) begin
      sel = 2'd1; pa = 32'(ua - 64'h1001_0000);
    end else if (ua >= 64'h7fff_effc + 4 - DIV && ua <= 64'h7fff_efff) begin
      sel = 2'd2; pa = 32'(longint'(DIV) - (64'h7fff_f000 - ua));
    end else if (ua >= 64'hffff_0000 && ua <= 64'hffff_0000 + MMIO_SZ - 1) begin
      sel = 2'd3; pa = 32'(ua - 64'hffff_0000);
    end else begin
      hit = 1'b0;
    end
    case (sz)
      2'd0:    be = 4'(1 << (a % 4));
      2'd1:    be = 4'(3 << (a % 4));
      default: be = 4'hF;
    endcase
    err = !hit || (sz == 2'd3) || (sz == 2'd2 && (a % 4) != 0) ||
          (sz == 2'd1 && (a % 2) != 0) || (we && hit && sel == 2'd0);
    lat = err ? 1 : 3;
`ifdef MEM_MAP_MMIO_WAIT_EN
    if (!err && sel == 2'd3) lat = 3 + WAIT_P;
`endif
  endfunction

  task automatic checkResetValues();
    checkOutput("rst_req_ready", bus.req_ready, 1);
    checkOutput("rst_mem_en", bus.mem_en, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_sel", bus.mem_sel, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_be", bus.mem_be, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("rst_rsp_err", bus.rsp_err, 0);
  endtask

  // One request; memory returns rdata only from the cycle after mem_en, with hold stall cycles in RESP.
  task automatic applyStimulus(input logic [31:0] addr, input bit we, input logic [1:0] sz,
                               input logic [31:0] wdata, input logic [31:0] rdata, input int hold);
    bit err, done;
    logic [1:0] sel;
    logic [31:0] pa, expData;
    logic [3:0] be;
    int lat, cyc, first, enCnt, enCyc, held;
    logic [1:0] enSel;
    logic [31:0] enAddr, enWdata;
    logic [3:0] enBe;
    logic enWe;

    refModel(addr, we, sz, err, sel, pa, be, lat);
    expData = (err || we) ? 32'd0 : rdata;
    cyc = 0; first = -1; enCnt = 0; enCyc = -1; held = 0; done = 1'b0;
    enSel = '0; enAddr = '0; enWdata = '0; enBe = '0; enWe = 1'b0;

    @(negedge clk);
    checkOutput("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_wdata = wdata;
    bus.mem_rdata = $urandom;
    bus.rsp_ready = 1'b0;
    @(posedge clk);

    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      checkOutput("req_ready_busy", bus.req_ready, 0);
      if (bus.mem_en) begin
        enCnt++;
        if (enCyc < 0) begin
          enCyc = cyc; enSel = bus.mem_sel; enAddr = bus.mem_addr;
          enBe = bus.mem_be; enWe = bus.mem_we; enWdata = bus.mem_wdata;
        end
      end
      if (bus.rsp_valid) begin
        if (first < 0) first = cyc;
        checkOutput("rsp_rdata", bus.rsp_rdata, expData);
        checkOutput("rsp_err", bus.rsp_err, err);
        if (held < hold) begin
          held++;
        end else begin
          bus.rsp_ready = 1'b1;
          bus.req_valid = 1'b0;
          done = 1'b1;
        end
      end
      if (!done) begin
        @(posedge clk);
        #1;
        bus.mem_rdata = (enCyc > 0) ? rdata : $urandom;
      end
    end

    if (!done) begin
      checkOutput("rsp_timeout", 64'(first), 64'(lat));
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_latency", 64'(first), 64'(lat));
    checkOutput("mem_en_count", 64'(enCnt), err ? 64'd0 : 64'd1);
    checkOutput("post_rsp_valid", bus.rsp_valid, 0);
    checkOutput("post_req_ready", bus.req_ready, 1);
    if (!err) begin
      checkOutput("mem_en_cycle", 64'(enCyc), 64'd1);
      checkOutput("mem_sel", enSel, sel);
      checkOutput("mem_addr", enAddr, pa);
      checkOutput("mem_be", enBe, be);
      checkOutput("mem_we", enWe, we);
      if (we) checkOutput("mem_wdata", enWdata, wdata);
    end
  endtask

  initial begin
    logic [31:0] base, span, addr;
    int region, kind;
    logic [1:0] sz;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_size  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues();
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(32'h1001_0008, 1'b0, 2'd2, 32'h0, 32'hDEAD_BEEF, 0);
    applyStimulus(32'h7fff_effd, 1'b1, 2'd0, 32'h0000_5A00, 32'h1234_5678, 0);
    applyStimulus(32'h0040_0010, 1'b1, 2'd2, 32'hCAFE_F00D, 32'h1111_1111, 0);
    applyStimulus(32'h1001_0001, 1'b0, 2'd1, 32'h0, 32'h2222_2222, 0);
    applyStimulus(32'hffff_0004, 1'b0, 2'd2, 32'h0, 32'hA5A5_0004, 0);
    applyStimulus(32'h1001_0100, 1'b0, 2'd2, 32'h0, 32'h0BAD_CAFE, 4);
    applyStimulus(32'h0040_0000, 1'b0, 2'd3, 32'h0, 32'h3333_3333, 0);
    applyStimulus(32'h0800_0000, 1'b0, 2'd0, 32'h0, 32'h4444_4444, 0);

    $display("[TB] randomized cases");
    for (int i = 0; i < 60; i++) begin
      region = $urandom_range(0, 4);
      case (region)
        0:       begin base = 32'h0040_0000;      span = INST;    end
        1:       begin base = 32'h1001_0000;      span = DIV;     end
        2:       begin base = 32'h7fff_f000 - DIV; span = DIV;    end
        3:       begin base = 32'hffff_0000;      span = MMIO_SZ; end
        default: begin base = $urandom;           span = 1;       end
      endcase
      kind = $urandom_range(0, 5);
      case (kind)
        0:       addr = base;
        1:       addr = base + span - 1;
        2:       addr = base - 1;
        3:       addr = base + span;
        default: addr = base + $urandom_range(0, span - 1);
      endcase
      sz = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
      applyStimulus(addr, 1'($urandom_range(0, 1)), sz, $urandom, $urandom,
                    $urandom_range(0, 3));
    end

    $display("[TB] reset during ACCESS");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1001_0010;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_wdata = 32'h7777_7777;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("access_mem_en", bus.mem_en, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetValues();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("abandoned_rsp_valid", bus.rsp_valid, 0);
      checkOutput("abandoned_mem_en", bus.mem_en, 0);
    end
    applyStimulus(32'h1001_0014, 1'b0, 2'd2, 32'h0, 32'h5555_AAAA, 1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_map_ctrl.md
MEM_MAP_CTRL -- requirements
Module: mem_map_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address/data width.
REQ-002 The block SHALL have parameter INST_MEM_DEPTH, default 1024, meaning text window size in bytes.
REQ-003 The block SHALL have parameter DATA_MEM_DEPTH, default 4096, meaning data+stack memory size in bytes; DIV = DATA_MEM_DEPTH/2.
REQ-004 The block SHALL have parameter MMIO_MEM_SIZE, default 64, meaning MMIO window size in bytes.
REQ-005 The block SHALL have parameter MMIO_WAIT, default 2, meaning MMIO wait cycles, range 1..15.
REQ-006 The block SHALL have ports: clk in 1 clock; rst in 1 reset; req_valid in 1; req_ready out 1; req_addr in ADDR_W; req_we in 1; req_size in 2 (0 byte, 1 half, 2 word, 3 illegal); req_wdata in ADDR_W.
REQ-007 The block SHALL have ports: mem_en out 1; mem_we out 1; mem_sel out 2 (0 TEXT, 1 DATA, 2 STACK, 3 MMIO); mem_addr out ADDR_W physical byte index; mem_be out 4; mem_wdata out ADDR_W; mem_rdata in ADDR_W.
REQ-008 The block SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out ADDR_W; rsp_err out 1.
REQ-009 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-010 Decode windows SHALL be: TEXT [0x00400000, +INST_MEM_DEPTH-1]; DATA [0x10010000, +DIV-1]; STACK [0x7fffeffc+4-DIV, 0x7fffefff]; MMIO [0xffff0000, +MMIO_MEM_SIZE-1].
REQ-011 mem_addr SHALL be req_addr minus the window base for TEXT, DATA and MMIO, and DIV + (req_addr - STACK base) for STACK, with 32-bit modular arithmetic.
REQ-012 An error SHALL be flagged for any of: address in no window; word with addr[1:0]!=0; half with addr[0]!=0; req_size==3; write to TEXT.
REQ-013 mem_be SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, and 4'b1111 for word.
REQ-014 FSM states SHALL be IDLE, ACCESS, WAIT, DATA and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 A handshake (req_valid&&req_ready) at edge k SHALL register the request; on error the next state SHALL be RESP, otherwise ACCESS.
REQ-016 In ACCESS, mem_en SHALL be 1 for exactly one cycle with registered we, sel, addr, be and wdata; mem_en SHALL be 0 in all other states.
REQ-017 ACCESS SHALL go to DATA, or to WAIT for MMIO when configured; DATA SHALL capture mem_rdata into rsp_rdata and go to RESP.
REQ-018 Non-error latency SHALL be rsp_valid first high in cycle k+3; error latency SHALL be rsp_valid high in cycle k+1 with rsp_err=1, rsp_rdata=0 and no mem_en.
REQ-019 In RESP, rsp_valid SHALL hold, with rsp_rdata and rsp_err stable, until rsp_ready=1; that edge SHALL return to IDLE.
REQ-020 Write responses SHALL return rsp_rdata=0.
REQ-021 req_valid SHALL be ignored outside IDLE; no request queuing.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE from any state, abandon in-flight requests without a response, and set req_ready=1, mem_en=0, mem_we=0, mem_sel=0, mem_addr=0, mem_be=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and the wait counter to 0.

Configuration
REQ-023 With macro MEM_MAP_MMIO_WAIT_EN defined, MMIO accesses SHALL pass ACCESS -> WAIT for MMIO_WAIT cycles -> DATA, giving first rsp_valid at k+3+MMIO_WAIT.
REQ-024 Without MEM_MAP_MMIO_WAIT_EN, the WAIT state and counter SHALL be absent, and MMIO latency SHALL equal other regions (k+3).

Verification
REQ-025 Word read 0x10010008, mem_rdata=0xDEADBEEF -> mem_sel=1, mem_addr=8, mem_be=4'hF at k+1; rsp_valid at k+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-026 Byte write 0x7fffeffd, DATA_MEM_DEPTH=4096 -> mem_sel=2, mem_addr=0x7fd, mem_be=4'b0010, mem_we=1.
REQ-027 Word write to 0x00400010, and half read to 0x10010001 -> each rsp_err=1 at k+1, mem_en never asserted.
REQ-028 MMIO read 0xffff0004 with MEM_MAP_MMIO_WAIT_EN, MMIO_WAIT=2 -> rsp_valid at k+5; without the macro -> rsp_valid at k+3.
REQ-029 Hold rsp_ready=0 for 4 cycles in RESP, with req_valid asserted -> rsp_valid/rsp_rdata stable, req_ready=0, no new mem_en; accept on release.
REQ-030 Assert rst during ACCESS -> IDLE next cycle, all outputs at reset values, no rsp_valid for the abandoned request.
